rv32i_mc_control: RTL and testbench
===================================

Name: rv32i_mc_control

Overview:
- Multi-cycle main controller for the RV32I core; successor to the single-cycle opcode decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB with a valid/ready memory handshake.
- Adds U-type (LUI/AUIPC), a memory timeout trap, a run/halt control and a retired-instruction counter.
- Sits between the datapath (PC, IR, ALU, rd_data mux) and the unified instruction/data memory port.

Parameters:
- SUPPORT_U, 1, 1 = LUI/AUIPC legal; 0 = both decode as illegal.
- MEM_TIMEOUT, 16, max cycles mem_req may wait for mem_ready before trapping; 0 = no timeout.
- CNT_W, 32, width of the instret counter.

Ports:
- clk, input, 1, core clock.
- rst, input, 1, reset: synchronous to clk, active-high.
- run, input, 1, allows a new instruction to start.
- opcode, input, 7, IR[6:0] from the datapath.
- branch_taken, input, 1, branch comparison result from the ALU, valid in EXEC.
- mem_ready, input, 1, memory completes the request in this cycle.
- mem_req, output, 1, memory request valid.
- mem_we, output, 1, request is a write (store).
- mem_addr_sel, output, 1, 0 = PC (fetch), 1 = ALU result (load/store).
- ir_we, output, 1, latch the fetched instruction.
- pc_we, output, 1, update the PC.
- pc_src, output, 2, 00 = PC+4, 01 = PC+imm (taken branch/JAL), 10 = (rs1+imm)&~1 (JALR).
- alu_src, output, 1, 1 = imm, 0 = rs2.
- alu_opa_pc, output, 1, 1 = ALU operand A is PC (AUIPC).
- alu_op_main, output, 2, 00 add/I-arith, 01 R/S, 10 JAL, 11 branch; AUIPC uses 00.
- imm_type, output, 3, 000 I, 001 S, 010 B, 011 J, 100 U.
- mem_to_reg, output, 2, 00 mem, 01 ALU, 10 PC+4, 11 imm (LUI).
- reg_write, output, 1, rd write enable.
- trap, output, 1, sticky illegal-opcode or timeout indication.
- trap_cause, output, 1, 0 = illegal opcode, 1 = memory timeout.
- state, output, 3, current state, for debug.
- instret, output, CNT_W, retired instruction count.

Behaviour:
- State encoding: IDLE = 0, FETCH = 1, DECODE = 2, EXEC = 3, MEM = 4, WB = 5, TRAP = 6.
- Reset: state = IDLE, instret = 0, trap = 0, trap_cause = 0, decode register cleared; all other outputs are 0 while in IDLE.
- Reset mid-operation aborts immediately, including during a pending memory request.
- All outputs are combinational from the state register and the decode register; there are no combinational paths from opcode.

State transitions:
- IDLE: go to FETCH when run = 1.
- FETCH: mem_req = 1, mem_addr_sel = 0. When mem_ready = 1, assert ir_we that cycle and go to DECODE.
- DECODE: register the decode of opcode (alu_src, alu_op_main, imm_type, mem_to_reg, instruction class). Unknown opcode, or LUI/AUIPC with SUPPORT_U = 0, goes to TRAP with cause 0; otherwise go to EXEC.
- EXEC (one cycle):
  - Branch: pc_we = 1, pc_src = 01 if branch_taken else 00; then retire.
  - LOAD/STORE: go to MEM.
  - All other classes: go to WB.
- MEM: mem_req = 1, mem_addr_sel = 1, mem_we = 1 for stores.
  - On mem_ready, a store asserts pc_we (pc_src 00) and retires.
  - On mem_ready, a load goes to WB.
- WB: reg_write = 1, pc_we = 1. pc_src = 01 for JAL, 10 for JALR, else 00. mem_to_reg: load 00, R/OP_IMM/AUIPC 01, JAL/JALR 10, LUI 11. Then retire.

Retire:
- instret increments by 1 and wraps modulo 2^CNT_W.
- Next state is FETCH if run = 1, else IDLE. A halt takes effect only at an instruction boundary.

Memory timeout:
- A counter clears on entry to FETCH/MEM and increments each cycle mem_req = 1 and mem_ready = 0.
- When MEM_TIMEOUT != 0 and the count reaches MEM_TIMEOUT - 1 while mem_ready = 0, go to TRAP with cause 1.
- mem_ready arriving in that same cycle wins, so no trap occurs.

TRAP:
- trap = 1; all strobes (mem_req, pc_we, reg_write, ir_we) are 0.
- Held until rst; instret is frozen.

Timing: minimum cycles per instruction with zero-wait memory: branch 3, R/I/JAL/JALR/U 4, store 4, load 5.

Test Plan:
- Reset, run = 1, ADD (0110011), mem_ready always 1 -> states 1,2,3,5; reg_write = 1 and mem_to_reg = 01 in WB; pc_we once; instret = 1 after 4 cycles.
- LW with mem_ready low for 3 cycles in MEM (MEM_TIMEOUT = 16) -> mem_req held 4 cycles with mem_addr_sel = 1; WB mem_to_reg = 00; total 8 cycles.
- BEQ with branch_taken = 1, then again with 0 -> pc_we in EXEC with pc_src 01, then 00; reg_write never 1; 3 cycles each.
- JALR, then LUI with SUPPORT_U = 1 -> pc_src 10 and mem_to_reg 10; then imm_type 100 and mem_to_reg 11. With SUPPORT_U = 0, LUI -> trap = 1, trap_cause = 0, state 6.
- MEM_TIMEOUT = 4, mem_ready held 0 in FETCH -> trap asserts on the 5th cycle after FETCH entry with cause 1. Repeat with mem_ready = 1 on the 4th cycle -> no trap.
- run dropped mid-STORE -> store completes, instret increments, state goes to IDLE; rst asserted in MEM -> state 0, mem_req = 0 the next cycle.

Source files
------------

// File: rtl/rv32i_mc_control.sv
// rv32i_mc_control -- multi-cycle main controller for the RV32I core.
//
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the
// unified instruction/data memory port with a valid/ready handshake.
// A wait counter traps requests that stall too long. Illegal opcodes also
// trap. Traps stick until rst. A retired-instruction counter is kept, and a
// run/halt input stops the core at instruction boundaries.
//
// Ports:
//   clk, rst          core clock, synchronous active-high reset
//   run               allows a new instruction to start
//   opcode            IR[6:0] from the datapath (sampled only in DECODE)
//   branch_taken      ALU branch comparison, used in EXEC
//   mem_ready         memory completes the current request this cycle
//   mem_req/mem_we    memory request valid / request is a store
//   mem_addr_sel      0 = PC (fetch), 1 = ALU result (load/store)
//   ir_we, pc_we      instruction register / PC write enables
//   pc_src            00 PC+4, 01 PC+imm, 10 (rs1+imm)&~1
//   alu_src           1 = imm, 0 = rs2
//   alu_opa_pc        ALU operand A is PC (AUIPC)
//   alu_op_main       00 add/I-arith, 01 R/S, 10 JAL, 11 branch
//   imm_type          000 I, 001 S, 010 B, 011 J, 100 U
//   mem_to_reg        00 mem, 01 ALU, 10 PC+4, 11 imm
//   reg_write         rd write enable
//   trap, trap_cause  sticky trap, cause 0 = illegal opcode, 1 = mem timeout
//   state             current FSM state (debug)
//   instret           retired instruction count
module rv32i_mc_control #(
  parameter int unsigned SUPPORT_U   = 1,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             alu_src,
  output logic             alu_opa_pc,
  output logic [1:0]       alu_op_main,
  output logic [2:0]       imm_type,
  output logic [1:0]       mem_to_reg,
  output logic             reg_write,
  output logic             trap,
  output logic             trap_cause,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    C_OP, C_OP_IMM, C_LOAD, C_STORE, C_BRANCH,
    C_JAL, C_JALR, C_LUI, C_AUIPC, C_ILLEGAL
  } class_t;

  typedef struct packed {
    class_t     cls;
    logic       alu_src;
    logic       alu_opa_pc;
    logic [1:0] alu_op;
    logic [2:0] imm;
    logic [1:0] m2r;
  } dec_t;

  // The wait counter only has to reach MEM_TIMEOUT-1.
  localparam int unsigned TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  dec_t             dec_d, dec_q;
  logic [TW-1:0]    wait_cnt;
  logic             timeout_hit;
  logic             retire;
  logic             cause_q;
  logic [CNT_W-1:0] instret_q;

  // Opcode decode; only ever captured into dec_q, never drives outputs directly.
  always_comb begin
    dec_d     = '0;
    dec_d.cls = C_ILLEGAL;
    case (opcode)
      7'b0110011: begin
        dec_d.cls = C_OP;     dec_d.alu_op = 2'b01; dec_d.m2r = 2'b01;
      end
      7'b0010011: begin
        dec_d.cls = C_OP_IMM; dec_d.alu_src = 1'b1; dec_d.imm = 3'b000; dec_d.m2r = 2'b01;
      end
      7'b0000011: begin
        dec_d.cls = C_LOAD;   dec_d.alu_src = 1'b1; dec_d.imm = 3'b000; dec_d.m2r = 2'b00;
      end
      7'b0100011: begin
        dec_d.cls = C_STORE;  dec_d.alu_src = 1'b1; dec_d.alu_op = 2'b01; dec_d.imm = 3'b001;
      end
      7'b1100011: begin
        dec_d.cls = C_BRANCH; dec_d.alu_op = 2'b11; dec_d.imm = 3'b010;
      end
      7'b1101111: begin
        dec_d.cls = C_JAL;    dec_d.alu_src = 1'b1; dec_d.alu_op = 2'b10;
        dec_d.imm = 3'b011;   dec_d.m2r = 2'b10;
      end
      7'b1100111: begin
        dec_d.cls = C_JALR;   dec_d.alu_src = 1'b1; dec_d.imm = 3'b000; dec_d.m2r = 2'b10;
      end
      7'b0110111: begin
        if (SUPPORT_U != 0) begin
          dec_d.cls = C_LUI;  dec_d.alu_src = 1'b1; dec_d.imm = 3'b100; dec_d.m2r = 2'b11;
        end
      end
      7'b0010111: begin
        if (SUPPORT_U != 0) begin
          dec_d.cls = C_AUIPC; dec_d.alu_src = 1'b1; dec_d.alu_opa_pc = 1'b1;
          dec_d.imm = 3'b100;  dec_d.m2r = 2'b01;
        end
      end
      default: ;
    endcase
  end

  // mem_ready in the final cycle takes priority over the timeout.
  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == TO_LAST) && !mem_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready)        state_d = S_DECODE;
        else if (timeout_hit) state_d = S_TRAP;
      end
      S_DECODE: state_d = (dec_d.cls == C_ILLEGAL) ? S_TRAP : S_EXEC;
      S_EXEC: begin
        case (dec_q.cls)
          C_BRANCH:        retire  = 1'b1;
          C_LOAD, C_STORE: state_d = S_MEM;
          default:         state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          if (dec_q.cls == C_STORE) retire  = 1'b1;
          else                      state_d = S_WB;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
        end
      end
      S_WB:     retire  = 1'b1;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_IDLE;
    endcase
    if (retire) state_d = run ? S_FETCH : S_IDLE;
  end

  // Decode register, wait counter, trap cause and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_q     <= '0;
      wait_cnt  <= '0;
      cause_q   <= 1'b0;
      instret_q <= '0;
    end else begin
      if (state_q == S_DECODE) dec_q <= dec_d;
      // Any state change clears the counter, which covers entry to FETCH and MEM.
      if (state_d != state_q)          wait_cnt <= '0;
      else if (mem_req && !mem_ready)  wait_cnt <= wait_cnt + TW'(1);
      if (state_q != S_TRAP && state_d == S_TRAP) cause_q <= (state_q != S_DECODE);
      if (retire) instret_q <= instret_q + CNT_W'(1);
    end
  end

  // Output logic: a function of state_q and dec_q only (plus the handshake inputs).
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 2'b00;
    alu_src      = 1'b0;
    alu_opa_pc   = 1'b0;
    alu_op_main  = 2'b00;
    imm_type     = 3'b000;
    mem_to_reg   = 2'b00;
    reg_write    = 1'b0;
    trap         = 1'b0;
    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      alu_src     = dec_q.alu_src;
      alu_opa_pc  = dec_q.alu_opa_pc;
      alu_op_main = dec_q.alu_op;
      imm_type    = dec_q.imm;
    end
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ready;
      end
      S_EXEC: begin
        if (dec_q.cls == C_BRANCH) begin
          pc_we  = 1'b1;
          pc_src = branch_taken ? 2'b01 : 2'b00;
        end
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (dec_q.cls == C_STORE);
        pc_we        = (dec_q.cls == C_STORE) && mem_ready;
      end
      S_WB: begin
        reg_write  = 1'b1;
        pc_we      = 1'b1;
        mem_to_reg = dec_q.m2r;
        if (dec_q.cls == C_JAL)       pc_src = 2'b01;
        else if (dec_q.cls == C_JALR) pc_src = 2'b10;
      end
      S_TRAP: trap = 1'b1;
      default: ;
    endcase
  end

  assign trap_cause = cause_q;
  assign state      = state_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_rv32i_mc_control.sv
// Testbench for rv32i_mc_control. Two instances: A (SUPPORT_U=1,
// MEM_TIMEOUT=16, CNT_W=32) and B (SUPPORT_U=0, MEM_TIMEOUT=4, CNT_W=3).
// The unselected instance is held in reset. Expected behaviour comes from a
// per-instruction phase list built from the instruction class.
module tb_rv32i_mc_control;

  localparam int P_IDLE = 0, P_FETCH = 1, P_DECODE = 2, P_EXEC = 3,
                 P_MEM = 4, P_WB = 5, P_TRAP = 6;
  localparam int K_OP = 0, K_OPI = 1, K_LD = 2, K_ST = 3, K_BR = 4,
                 K_JAL = 5, K_JALR = 6, K_LUI = 7, K_AUIPC = 8;

  typedef struct {
    bit       legal;
    int       kind;
    bit       src_v;
    bit       src;
    bit       op_v;
    bit [1:0] aop;
    bit       imm_v;
    bit [2:0] imm;
    bit [1:0] m2r;
    bit       opa;
  } ref_t;

  typedef struct {
    int ph;
    bit rdy;
    bit ret;
  } cyc_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0, run = 1'b0, branch_taken = 1'b0, mem_ready = 1'b0;
  logic [6:0] opcode = '0;
  logic       sel = 1'b0;
  logic       rst_a, rst_b;
  assign rst_a = rst | sel;
  assign rst_b = rst | ~sel;

  logic        a_mem_req, a_mem_we, a_mem_addr_sel, a_ir_we, a_pc_we, a_alu_src, a_alu_opa_pc;
  logic        a_reg_write, a_trap, a_trap_cause;
  logic [1:0]  a_pc_src, a_alu_op_main, a_mem_to_reg;
  logic [2:0]  a_imm_type, a_state;
  logic [31:0] a_instret;
  logic        b_mem_req, b_mem_we, b_mem_addr_sel, b_ir_we, b_pc_we, b_alu_src, b_alu_opa_pc;
  logic        b_reg_write, b_trap, b_trap_cause;
  logic [1:0]  b_pc_src, b_alu_op_main, b_mem_to_reg;
  logic [2:0]  b_imm_type, b_state;
  logic [2:0]  b_instret;

  rv32i_mc_control #(.SUPPORT_U(1), .MEM_TIMEOUT(16), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst_a), .run(run), .opcode(opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(a_mem_req), .mem_we(a_mem_we),
    .mem_addr_sel(a_mem_addr_sel), .ir_we(a_ir_we), .pc_we(a_pc_we), .pc_src(a_pc_src),
    .alu_src(a_alu_src), .alu_opa_pc(a_alu_opa_pc), .alu_op_main(a_alu_op_main),
    .imm_type(a_imm_type), .mem_to_reg(a_mem_to_reg), .reg_write(a_reg_write),
    .trap(a_trap), .trap_cause(a_trap_cause), .state(a_state), .instret(a_instret));

  rv32i_mc_control #(.SUPPORT_U(0), .MEM_TIMEOUT(4), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst_b), .run(run), .opcode(opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(b_mem_req), .mem_we(b_mem_we),
    .mem_addr_sel(b_mem_addr_sel), .ir_we(b_ir_we), .pc_we(b_pc_we), .pc_src(b_pc_src),
    .alu_src(b_alu_src), .alu_opa_pc(b_alu_opa_pc), .alu_op_main(b_alu_op_main),
    .imm_type(b_imm_type), .mem_to_reg(b_mem_to_reg), .reg_write(b_reg_write),
    .trap(b_trap), .trap_cause(b_trap_cause), .state(b_state), .instret(b_instret));

  // Observed outputs of the selected instance.
  logic [6:0]  o_str;   // {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, reg_write, trap}
  logic [2:0]  o_state, o_imm;
  logic [1:0]  o_pcs, o_aop, o_m2r;
  logic        o_src, o_opa, o_cause;
  logic [31:0] o_instret;
  assign o_str = sel ? {b_mem_req, b_mem_we, b_mem_addr_sel, b_ir_we, b_pc_we, b_reg_write, b_trap}
                     : {a_mem_req, a_mem_we, a_mem_addr_sel, a_ir_we, a_pc_we, a_reg_write, a_trap};
  assign o_state   = sel ? b_state       : a_state;
  assign o_imm     = sel ? b_imm_type    : a_imm_type;
  assign o_pcs     = sel ? b_pc_src      : a_pc_src;
  assign o_aop     = sel ? b_alu_op_main : a_alu_op_main;
  assign o_m2r     = sel ? b_mem_to_reg  : a_mem_to_reg;
  assign o_src     = sel ? b_alu_src     : a_alu_src;
  assign o_opa     = sel ? b_alu_opa_pc  : a_alu_opa_pc;
  assign o_cause   = sel ? b_trap_cause  : a_trap_cause;
  assign o_instret = sel ? {29'd0, b_instret} : a_instret;

  int          vec = 0;
  int          errs = 0;
  logic [31:0] instret_m = '0;
  bit          cur_idle = 1'b1;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

  // Reference instruction table.
  function automatic ref_t ref_decode(input logic [6:0] op, input bit u_ok);
    ref_t r;
    r = '{legal: 1'b0, kind: 0, src_v: 1'b0, src: 1'b0, op_v: 1'b0, aop: 2'b00,
          imm_v: 1'b0, imm: 3'b000, m2r: 2'b00, opa: 1'b0};
    r.legal = 1'b1;
    case (op)
      OP_R:     begin r.kind = K_OP;   r.src_v = 1; r.src = 0; r.op_v = 1; r.aop = 2'b01; r.m2r = 2'b01; end
      OP_I:     begin r.kind = K_OPI;  r.src_v = 1; r.src = 1; r.op_v = 1; r.aop = 2'b00;
                      r.imm_v = 1; r.imm = 3'b000; r.m2r = 2'b01; end
      OP_LD:    begin r.kind = K_LD;   r.src_v = 1; r.src = 1; r.op_v = 1; r.aop = 2'b00;
                      r.imm_v = 1; r.imm = 3'b000; r.m2r = 2'b00; end
      OP_ST:    begin r.kind = K_ST;   r.src_v = 1; r.src = 1; r.imm_v = 1; r.imm = 3'b001; end
      OP_BR:    begin r.kind = K_BR;   r.src_v = 1; r.src = 0; r.op_v = 1; r.aop = 2'b11;
                      r.imm_v = 1; r.imm = 3'b010; end
      OP_JAL:   begin r.kind = K_JAL;  r.op_v = 1; r.aop = 2'b10; r.imm_v = 1; r.imm = 3'b011; r.m2r = 2'b10; end
      OP_JALR:  begin r.kind = K_JALR; r.src_v = 1; r.src = 1; r.op_v = 1; r.aop = 2'b00;
                      r.imm_v = 1; r.imm = 3'b000; r.m2r = 2'b10; end
      OP_LUI:   begin r.kind = K_LUI;  r.legal = u_ok; r.imm_v = 1; r.imm = 3'b100; r.m2r = 2'b11; end
      OP_AUIPC: begin r.kind = K_AUIPC; r.legal = u_ok; r.src_v = 1; r.src = 1; r.op_v = 1;
                      r.aop = 2'b00; r.imm_v = 1; r.imm = 3'b100; r.m2r = 2'b01; r.opa = 1; end
      default:  r.legal = 1'b0;
    endcase
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; run = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0; opcode = '0;
    @(negedge clk);
    rst = 1'b0;
    instret_m = '0;
    cur_idle  = 1'b1;
  endtask

  // Runs one instruction against the expected phase list; fw/mw are the
  // numbers of not-ready cycles before mem_ready in FETCH / MEM.
  task automatic run_instr(input logic [6:0] op, input bit taken, input int fw, input int mw,
                           input int extra_idle, input bit run_after, output bit trapped);
    cyc_t        q[$];
    ref_t        r, er;
    int          to, idle_n, e_state;
    bit          cause;
    logic [31:0] mask;
    logic [6:0]  e_str;
    logic [1:0]  e_pcs;
    bit          pcs_chk, sel_chk, m2r_chk;
    to      = sel ? 4 : 16;
    mask    = sel ? 32'h7 : 32'hFFFF_FFFF;
    r       = ref_decode(op, !sel);
    trapped = 1'b0;
    cause   = 1'b0;
    idle_n  = cur_idle ? 1 + extra_idle : 0;
    for (int i = 0; i < idle_n; i++) q.push_back('{P_IDLE, 1'($urandom_range(0, 1)), 1'b0});
    if (to != 0 && fw >= to) begin
      for (int i = 0; i < to; i++) q.push_back('{P_FETCH, 1'b0, 1'b0});
      trapped = 1'b1; cause = 1'b1;
    end else begin
      for (int i = 0; i < fw; i++) q.push_back('{P_FETCH, 1'b0, 1'b0});
      q.push_back('{P_FETCH, 1'b1, 1'b0});
      q.push_back('{P_DECODE, 1'($urandom_range(0, 1)), 1'b0});
      if (!r.legal) begin
        trapped = 1'b1; cause = 1'b0;
      end else begin
        q.push_back('{P_EXEC, 1'($urandom_range(0, 1)), r.kind == K_BR});
        if (r.kind == K_LD || r.kind == K_ST) begin
          if (to != 0 && mw >= to) begin
            for (int i = 0; i < to; i++) q.push_back('{P_MEM, 1'b0, 1'b0});
            trapped = 1'b1; cause = 1'b1;
          end else begin
            for (int i = 0; i < mw; i++) q.push_back('{P_MEM, 1'b0, 1'b0});
            q.push_back('{P_MEM, 1'b1, r.kind == K_ST});
            if (r.kind == K_LD) q.push_back('{P_WB, 1'($urandom_range(0, 1)), 1'b1});
          end
        end else if (r.kind != K_BR) begin
          q.push_back('{P_WB, 1'($urandom_range(0, 1)), 1'b1});
        end
      end
    end
    if (trapped) for (int i = 0; i < 3; i++) q.push_back('{P_TRAP, 1'($urandom_range(0, 1)), 1'b0});

    opcode = op;
    foreach (q[k]) begin
      @(negedge clk);
      mem_ready    = q[k].rdy;
      branch_taken = (q[k].ph == P_EXEC) ? taken : 1'($urandom_range(0, 1));
      if (q[k].ph == P_IDLE) run = (k == idle_n - 1);
      else if (q[k].ret)     run = run_after;
      else                   run = 1'($urandom_range(0, 1));
      #1;
      e_str = '0; e_pcs = 2'b00; pcs_chk = 0; sel_chk = 0; m2r_chk = 0;
      er = r;
      e_state = q[k].ph;
      case (q[k].ph)
        P_IDLE: begin
          pcs_chk = 1; sel_chk = 1; m2r_chk = 1;
          er = '{legal: 1'b1, kind: 0, src_v: 1'b1, src: 1'b0, op_v: 1'b1, aop: 2'b00,
                 imm_v: 1'b1, imm: 3'b000, m2r: 2'b00, opa: 1'b0};
        end
        P_FETCH: e_str = {1'b1, 1'b0, 1'b0, q[k].rdy, 1'b0, 1'b0, 1'b0};
        P_EXEC: begin
          sel_chk = 1;
          if (r.kind == K_BR) begin
            e_str = 7'b0000100; pcs_chk = 1; e_pcs = taken ? 2'b01 : 2'b00;
          end
        end
        P_MEM: begin
          sel_chk = 1;
          e_str = {1'b1, r.kind == K_ST, 1'b1, 1'b0, (r.kind == K_ST) && q[k].rdy, 1'b0, 1'b0};
          pcs_chk = e_str[2];
        end
        P_WB: begin
          sel_chk = 1; m2r_chk = 1; pcs_chk = 1;
          e_str = 7'b0000110;
          e_pcs = (r.kind == K_JAL) ? 2'b01 : (r.kind == K_JALR) ? 2'b10 : 2'b00;
        end
        P_TRAP: e_str = 7'b0000001;
        default: ;
      endcase

      vec++;
      if (o_state !== 3'(e_state)) begin
        errs++; $display("FAIL state op=%b cyc=%0d got=%0d exp=%0d", op, k, o_state, e_state);
      end
      vec++;
      if (o_str !== e_str) begin
        errs++; $display("FAIL strobes op=%b cyc=%0d got=%b exp=%b", op, k, o_str, e_str);
      end
      vec++;
      if (o_cause !== ((q[k].ph == P_TRAP) ? cause : 1'b0)) begin
        errs++; $display("FAIL trap_cause op=%b cyc=%0d got=%b exp=%b", op, k, o_cause,
                         (q[k].ph == P_TRAP) ? cause : 1'b0);
      end
      vec++;
      if (o_instret !== instret_m) begin
        errs++; $display("FAIL instret op=%b cyc=%0d got=%0d exp=%0d", op, k, o_instret, instret_m);
      end
      if (pcs_chk) begin
        vec++;
        if (o_pcs !== e_pcs) begin
          errs++; $display("FAIL pc_src op=%b cyc=%0d got=%b exp=%b", op, k, o_pcs, e_pcs);
        end
      end
      if (sel_chk) begin
        vec++;
        if (o_opa !== er.opa) begin
          errs++; $display("FAIL alu_opa_pc op=%b cyc=%0d got=%b exp=%b", op, k, o_opa, er.opa);
        end
        if (er.src_v) begin
          vec++;
          if (o_src !== er.src) begin
            errs++; $display("FAIL alu_src op=%b cyc=%0d got=%b exp=%b", op, k, o_src, er.src);
          end
        end
        if (er.op_v) begin
          vec++;
          if (o_aop !== er.aop) begin
            errs++; $display("FAIL alu_op_main op=%b cyc=%0d got=%b exp=%b", op, k, o_aop, er.aop);
          end
        end
        if (er.imm_v) begin
          vec++;
          if (o_imm !== er.imm) begin
            errs++; $display("FAIL imm_type op=%b cyc=%0d got=%b exp=%b", op, k, o_imm, er.imm);
          end
        end
      end
      if (m2r_chk) begin
        vec++;
        if (o_m2r !== er.m2r) begin
          errs++; $display("FAIL mem_to_reg op=%b cyc=%0d got=%b exp=%b", op, k, o_m2r, er.m2r);
        end
      end
      if (q[k].ret) instret_m = (instret_m + 32'd1) & mask;
    end
    cur_idle = trapped ? 1'b0 : !run_after;
  endtask

  task automatic test_reset();
    sel = 1'b0;
    do_reset();
    #1;
    vec++;
    if (o_state !== 3'd0 || o_str !== 7'd0 || o_instret !== 32'd0 || o_cause !== 1'b0) begin
      errs++; $display("FAIL reset_outputs state=%0d strobes=%b instret=%0d cause=%b exp=0",
                       o_state, o_str, o_instret, o_cause);
    end
    vec++;
    if ({o_pcs, o_src, o_opa, o_aop, o_imm, o_m2r} !== 12'd0) begin
      errs++; $display("FAIL reset_selects got=%b exp=0", {o_pcs, o_src, o_opa, o_aop, o_imm, o_m2r});
    end
    @(negedge clk);
    #1;
    vec++;
    if (o_state !== 3'd0) begin
      errs++; $display("FAIL idle_hold got=%0d exp=0", o_state);
    end
  endtask

  task automatic test_add();
    bit t;
    run_instr(OP_R, 1'b0, 0, 0, 0, 1'b0, t);
  endtask

  task automatic test_load_wait();
    bit t;
    run_instr(OP_LD, 1'b0, 0, 3, 0, 1'b1, t);
  endtask

  task automatic test_branch();
    bit t;
    run_instr(OP_BR, 1'b1, 0, 0, 0, 1'b1, t);
    run_instr(OP_BR, 1'b0, 0, 0, 0, 1'b1, t);
  endtask

  task automatic test_jump_upper();
    bit t;
    run_instr(OP_JALR, 1'b0, 0, 0, 0, 1'b1, t);
    run_instr(OP_LUI, 1'b0, 0, 0, 0, 1'b1, t);
    run_instr(OP_AUIPC, 1'b0, 1, 0, 0, 1'b1, t);
    run_instr(OP_JAL, 1'b0, 0, 0, 0, 1'b1, t);
    run_instr(OP_I, 1'b0, 2, 0, 0, 1'b1, t);
  endtask

  task automatic test_halt_store();
    bit t;
    run_instr(OP_ST, 1'b0, 0, 1, 0, 1'b0, t);
    run_instr(OP_R, 1'b0, 0, 0, 2, 1'b1, t);
  endtask

  task automatic test_reset_mid();
    sel = 1'b0;
    do_reset();
    begin
      bit t;
      run_instr(OP_R, 1'b0, 0, 0, 0, 1'b1, t);
    end
    opcode = OP_LD;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      run = 1'b1; mem_ready = (c == 0); branch_taken = 1'b0;
      #1;
      vec++;
      if (o_state !== 3'(c + 1)) begin
        errs++; $display("FAIL rst_mid_seq cyc=%0d got=%0d exp=%0d", c, o_state, c + 1);
      end
    end
    vec++;
    if (o_str !== 7'b1010000 || o_instret !== 32'd1) begin
      errs++; $display("FAIL rst_mid_mem strobes=%b instret=%0d exp=1010000/1", o_str, o_instret);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; run = 1'b0;
    #1;
    vec++;
    if (o_state !== 3'd0 || o_str !== 7'd0 || o_instret !== 32'd0) begin
      errs++; $display("FAIL rst_mid_abort state=%0d strobes=%b instret=%0d exp=0/0/0",
                       o_state, o_str, o_instret);
    end
    instret_m = '0;
    cur_idle  = 1'b1;
  endtask

  task automatic test_u_disabled();
    bit t;
    sel = 1'b1;
    do_reset();
    run_instr(OP_LUI, 1'b0, 0, 0, 0, 1'b1, t);
    do_reset();
    run_instr(OP_AUIPC, 1'b0, 0, 0, 0, 1'b1, t);
    do_reset();
    run_instr(OP_R, 1'b0, 0, 0, 0, 1'b0, t);
  endtask

  task automatic test_timeout();
    bit t;
    sel = 1'b1;
    do_reset();
    run_instr(OP_R, 1'b0, 4, 0, 0, 1'b1, t);
    do_reset();
    run_instr(OP_R, 1'b0, 3, 0, 0, 1'b1, t);
    run_instr(OP_LD, 1'b0, 0, 3, 0, 1'b1, t);
    run_instr(OP_ST, 1'b0, 0, 4, 0, 1'b1, t);
    sel = 1'b0;
    do_reset();
    run_instr(OP_LD, 1'b0, 15, 15, 0, 1'b1, t);
    run_instr(OP_ST, 1'b0, 0, 16, 0, 1'b1, t);
  endtask

  task automatic test_counter_wrap();
    bit t;
    sel = 1'b1;
    do_reset();
    for (int i = 0; i < 11; i++) run_instr((i % 2) ? OP_BR : OP_I, 1'($urandom_range(0, 1)),
                                           0, 0, 0, 1'b1, t);
  endtask

  task automatic test_random();
    logic [6:0] ops [9];
    logic [6:0] op;
    bit         t;
    int         fw, mw;
    ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      do_reset();
      for (int n = 0; n < 120; n++) begin
        op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)];
        fw = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 17) : $urandom_range(0, 2);
        mw = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 17) : $urandom_range(0, 2);
        run_instr(op, 1'($urandom_range(0, 1)), fw, mw, $urandom_range(0, 2),
                  1'($urandom_range(0, 3) != 0), t);
        if (t) do_reset();
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_load_wait();
    test_branch();
    test_jump_upper();
    test_halt_store();
    test_reset_mid();
    test_u_disabled();
    test_timeout();
    test_counter_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
